// File: rtl/ahb_rr_burst_arb.sv
// Output-stage round-robin arbiter for one AHB bus-matrix slave port.
// Keeps the grant for fixed-length bursts (beat counter) and locked sequences.
module ahb_rr_burst_arb #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W    = 3
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam int PAD_W = 1 << PORT_W;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [PORT_W-1:0] port_reg, port_next;
  logic              no_port_reg, no_port_next;
  logic              hold_reg, hold_next;
  logic [3:0]        cnt_reg, cnt_next;

  logic [PAD_W-1:0]  req_pad;
  logic [PORT_W-1:0] cand [1:NUM_PORTS-1];
  logic [NUM_PORTS-1:1] hit;
  logic              rr_found;
  logic [PORT_W-1:0] rr_port;

  logic              sel_nonseq, sel_seq, terminate;
  logic              fixed_burst;
  logic [3:0]        load_val;

  assign req_pad = PAD_W'(req);

  // Candidate port at each rotation offset from the current owner.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_PORTS; gi++) begin : g_cand
      logic [PORT_W:0] sum;
      assign sum = {1'b0, port_reg} + (PORT_W+1)'(gi);
      assign cand[gi] = (sum >= (PORT_W+1)'(NUM_PORTS))
                        ? PORT_W'(sum - (PORT_W+1)'(NUM_PORTS))
                        : sum[PORT_W-1:0];
      assign hit[gi] = req_pad[cand[gi]];
    end
  endgenerate

  // Scan far-to-near so the nearest requester overwrites the others.
  always_comb begin
    rr_found = 1'b0;
    rr_port  = port_reg;
    for (int k = NUM_PORTS - 1; k >= 1; k--) begin
      if (hit[k]) begin
        rr_found = 1'b1;
        rr_port  = cand[k];
      end
    end
  end

  assign sel_nonseq = HSELM & (HTRANSM == TR_NONSEQ);
  assign sel_seq    = HSELM & (HTRANSM == TR_SEQ);
  assign terminate  = hold_reg & (~HSELM | (HTRANSM == TR_IDLE) | (HTRANSM == TR_NONSEQ));

  always_comb begin
    fixed_burst = 1'b1;
    load_val    = 4'd0;
    case (HBURSTM)
      3'b010, 3'b011: load_val = 4'd3;
      3'b100, 3'b101: load_val = 4'd7;
      3'b110, 3'b111: load_val = 4'd15;
      default:        fixed_burst = 1'b0;
    endcase
  end

  // Beat counter; a terminating NONSEQ that starts a new fixed burst reloads.
  always_comb begin
    cnt_next  = cnt_reg;
    hold_next = hold_reg;
    if (sel_nonseq && fixed_burst) begin
      cnt_next  = load_val;
      hold_next = 1'b1;
    end else if (terminate) begin
      cnt_next  = 4'd0;
      hold_next = 1'b0;
    end else if (hold_reg && sel_seq && (cnt_reg != 4'd0)) begin
      cnt_next  = cnt_reg - 4'd1;
      hold_next = (cnt_reg != 4'd1);
    end
  end

  // Grant freezes whenever the burst is still running after this edge, which
  // covers the first NONSEQ beat and releases on the last SEQ or termination.
  always_comb begin
    port_next    = port_reg;
    no_port_next = no_port_reg;
    if (HMASTLOCKM) begin
      port_next = port_reg;
    end else if (hold_next) begin
      no_port_next = 1'b0;
    end else if (rr_found) begin
      port_next    = rr_port;
      no_port_next = 1'b0;
    end else if (req_pad[port_reg] || (HSELM && (HTRANSM != TR_IDLE))) begin
      no_port_next = 1'b0;
    end else if (!HSELM) begin
      no_port_next = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      port_reg    <= '0;
      no_port_reg <= 1'b1;
      hold_reg    <= 1'b0;
      cnt_reg     <= 4'd0;
    end else if (HREADYM) begin
      port_reg    <= port_next;
      no_port_reg <= no_port_next;
      hold_reg    <= hold_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign addr_in_port = port_reg;
  assign no_port      = no_port_reg;
  assign burst_hold   = hold_reg;

endmodule
